// File: rtl/uart_tx_fsm_if.sv
// Handshake and serializer-side signals of the UART TX frame controller.
// master = request source / serializer side, slave = frame controller.
interface uart_tx_fsm_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              ser_data;
  logic              ser_done;
  logic              ser_en;
  logic              busy;
  logic              TX_OUT;
  logic              frame_err;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, busy, TX_OUT, frame_err
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, busy, TX_OUT, frame_err
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART TX frame controller: start bit, serializer data bits, optional parity, stop bit.
// ser_en and TX_OUT are decoded from registered state; busy and frame_err are registered.
module uart_tx_fsm #(
  parameter int unsigned DATA_W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fsm_if.slave   bus
);
  localparam int unsigned      CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] dcnt;
  logic             par_en_q;
  logic             par_bit;
  logic             busy_q;
  logic             frame_err_q;
  logic             accept;

  assign accept        = (state == IDLE) && bus.Data_Valid;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

  // Next state plus the line/shift-enable decode.
  always_comb begin
    next_state = state;
    bus.ser_en = 1'b0;
    bus.TX_OUT = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.Data_Valid) next_state = START;
      end
      START: begin
        bus.TX_OUT = 1'b0;
        bus.ser_en = 1'b1;
        next_state = DATA;
      end
      DATA: begin
        bus.TX_OUT = bus.ser_data;
        bus.ser_en = (dcnt != LAST);
        if (dcnt == LAST) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        bus.TX_OUT = par_bit;
        next_state = STOP;
      end
      STOP: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      dcnt        <= '0;
      par_en_q    <= 1'b0;
      par_bit     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
      if (accept) begin
        par_en_q    <= bus.PAR_EN;
        par_bit     <= (^bus.P_DATA) ^ bus.PAR_TYP;
        frame_err_q <= 1'b0;
        dcnt        <= '0;
      end else if (state == DATA) begin
        dcnt <= dcnt + CNT_W'(1);
        // ser_done must coincide with the last data bit; anything else is sticky.
        if (bus.ser_done != (dcnt == LAST)) frame_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a behavioural serializer and an
// expected-line scoreboard of {busy, TX_OUT} per cycle.
module tb_uart_tx_fsm;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  logic [1:0] exp_q[$];
  logic [7:0] sh;
  logic [2:0] scnt;
  logic       done_q;
  logic       force_done = 1'b0;

  uart_tx_fsm_if #(.DATA_W(8)) bus ();

  uart_tx_fsm #(.DATA_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.ser_done = done_q | force_done;

  // Serializer model: loads on acceptance, presents the next bit after each ser_en edge.
  always @(posedge CLK) begin
    if (!RST) begin
      sh           <= 8'h00;
      scnt         <= 3'd0;
      bus.ser_data <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.Data_Valid && !bus.busy) begin
        sh   <= bus.P_DATA;
        scnt <= 3'd0;
      end else if (bus.ser_en) begin
        bus.ser_data <= sh[scnt];
        done_q       <= (scnt == 3'd7);
        scnt         <= scnt + 3'd1;
      end
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    if (pe) exp_q.push_back({1'b1, (^d) ^ pt});
    exp_q.push_back(2'b11);
  endtask

  // Drive a request at a negedge and return right after the acceptance edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    push_frame(d, pe, pt);
    exp_q.push_back(2'b01);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      compared++;
      if ({bus.busy, bus.TX_OUT, bus.ser_en, bus.frame_err} !== 4'b0100) begin
        mismatched++;
        $display("FAIL reset_idle[%0d]: got busy,tx,ser_en,ferr=%b required 0100", k,
                 {bus.busy, bus.TX_OUT, bus.ser_en, bus.frame_err});
      end
    end
  endtask

  task automatic test_a5_even();
    logic [1:0] e;
    int         sen = 0;
    int         k   = 0;
    send(8'hA5, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      e = exp_q.pop_front();
      k++;
      if (bus.ser_en === 1'b1) sen++;
      compared++;
      if ({bus.busy, bus.TX_OUT} !== e) begin
        mismatched++;
        $display("FAIL a5_line[%0d]: got busy,tx=%b required %b", k, {bus.busy, bus.TX_OUT}, e);
      end
    end
    compared++;
    if (sen != 8) begin
      mismatched++;
      $display("FAIL a5_ser_en_cycles: got %0d required 8", sen);
    end
    compared++;
    if (bus.frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL a5_frame_err: got %b required 0", bus.frame_err);
    end
  endtask

  task automatic test_parity();
    logic [7:0] dt[3] = '{8'h01, 8'h03, 8'h3C};
    logic       pe[3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] e;
    int         k;
    for (int f = 0; f < 3; f++) begin
      send(dt[f], pe[f], 1'b1);
      k = 0;
      while (exp_q.size() > 0) begin
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        e = exp_q.pop_front();
        k++;
        compared++;
        if ({bus.busy, bus.TX_OUT} !== e) begin
          mismatched++;
          $display("FAIL parity%0d_line[%0d]: got busy,tx=%b required %b", f, k,
                   {bus.busy, bus.TX_OUT}, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int         k = 0;
    send(8'h55, 1'b0, 1'b0);
    push_frame(8'h55, 1'b0, 1'b0);
    repeat (3) exp_q.push_back(2'b01);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      k++;
      compared++;
      if ({bus.busy, bus.TX_OUT} !== e) begin
        mismatched++;
        $display("FAIL b2b_line[%0d]: got busy,tx=%b required %b", k, {bus.busy, bus.TX_OUT}, e);
      end
      // Held through frame 1 and its idle cycle; later only short mid-frame pulses.
      bus.Data_Valid = (k < 12) || (k == 15) || (k == 18);
    end
    bus.Data_Valid = 1'b0;
  endtask

  task automatic test_frame_err();
    logic [1:0] e;
    int         k = 0;
    send(8'h3C, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      e = exp_q.pop_front();
      k++;
      compared++;
      if ({bus.busy, bus.TX_OUT, bus.frame_err} !== {e, (k >= 7)}) begin
        mismatched++;
        $display("FAIL ferr_line[%0d]: got busy,tx,ferr=%b required %b", k,
                 {bus.busy, bus.TX_OUT, bus.frame_err}, {e, (k >= 7)});
      end
      force_done = (k == 6);
    end
    force_done = 1'b0;
    send(8'h3C, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      e = exp_q.pop_front();
      k++;
      compared++;
      if ({bus.busy, bus.TX_OUT, bus.frame_err} !== {e, 1'b0}) begin
        mismatched++;
        $display("FAIL ferr_clear[%0d]: got busy,tx,ferr=%b required %b", k,
                 {bus.busy, bus.TX_OUT, bus.frame_err}, {e, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] e;
    int         k = 0;
    send(8'h5A, 1'b0, 1'b0);
    for (k = 1; k <= 5; k++) begin
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      e = exp_q.pop_front();
      compared++;
      if ({bus.busy, bus.TX_OUT} !== e) begin
        mismatched++;
        $display("FAIL rst_pre[%0d]: got busy,tx=%b required %b", k, {bus.busy, bus.TX_OUT}, e);
      end
    end
    RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    compared++;
    if ({bus.busy, bus.TX_OUT, bus.ser_en} !== 3'b010) begin
      mismatched++;
      $display("FAIL rst_abort: got busy,tx,ser_en=%b required 010", {bus.busy, bus.TX_OUT, bus.ser_en});
    end
    RST = 1'b1;
    send(8'hC3, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      e = exp_q.pop_front();
      k++;
      compared++;
      if ({bus.busy, bus.TX_OUT} !== e) begin
        mismatched++;
        $display("FAIL rst_after[%0d]: got busy,tx=%b required %b", k, {bus.busy, bus.TX_OUT}, e);
      end
    end
  endtask

  initial begin
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    test_reset();
    test_a5_even();
    test_parity();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
